// File: rtl/muldiv_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// muldiv_pkg : operation and state encodings for the iterative mul/div unit
// Revision   : 1.0
//------------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
//------------------------------------------------------------------------------
// muldiv_step : one combinational iteration, shift-add multiply or restoring
//               divide, chosen by mode_div
// Revision    : 1.0
//------------------------------------------------------------------------------
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         mode_div,
  input  logic [N-1:0] acc,
  input  logic [N-1:0] low,
  input  logic [N-1:0] opnd,
  output logic [N-1:0] acc_nxt,
  output logic [N-1:0] low_nxt
);

  logic [N:0]   mul_sum;
  logic [N:0]   rem_sh;
  logic [N-1:0] rem_sub;
  logic         rem_ge;

  always_comb begin
    mul_sum = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc, low[N-1]};
    rem_ge  = rem_sh >= {1'b0, opnd};
    // When rem_ge holds the true difference is below 2^N, so N bits suffice.
    rem_sub = rem_sh[N-1:0] - opnd;
    if (mode_div) begin
      acc_nxt = rem_ge ? rem_sub : rem_sh[N-1:0];
      low_nxt = {low[N-2:0], rem_ge};
    end else begin
      acc_nxt = mul_sum[N:1];
      low_nxt = {mul_sum[0], low[N-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// muldiv_unit : iterative multiply/divide with architectural HI/LO registers
// Revision    : 1.0
//------------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  md_op_t       op,
  input  logic [N-1:0] srca,
  input  logic [N-1:0] srcb,
  input  logic         rdhilo,
  input  logic         flush,
  output logic         stall,
  output logic         busy,
  output logic         done,
  output logic         divzero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N + 1);

  md_state_t     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  acc_q, acc_d, low_q, low_d, opnd_q, opnd_d, orig_q, orig_d;
  logic [N-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic          neg_q, neg_d, negr_q, negr_d, isdiv_q, isdiv_d, dz_q, dz_d;
  logic          done_q, done_d, divzero_q, divzero_d;

  logic [N-1:0]   step_acc, step_low, mag_a, mag_b, quo_s, rem_s;
  logic [2*N-1:0] prod_s;
  logic           is_signed, sa, sb;

  muldiv_step #(.N(N)) u_step (
    .mode_div (state_q == ST_DIV),
    .acc      (acc_q),
    .low      (low_q),
    .opnd     (opnd_q),
    .acc_nxt  (step_acc),
    .low_nxt  (step_low)
  );

  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    sa        = is_signed & srca[N-1];
    sb        = is_signed & srcb[N-1];
    mag_a     = sa ? -srca : srca;
    mag_b     = sb ? -srcb : srcb;
    prod_s    = neg_q ? -{acc_q, low_q} : {acc_q, low_q};
    quo_s     = neg_q ? -low_q : low_q;
    rem_s     = negr_q ? -acc_q : acc_q;

    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    low_d     = low_q;
    opnd_d    = opnd_q;
    orig_d    = orig_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    negr_d    = negr_q;
    isdiv_d   = isdiv_q;
    dz_d      = dz_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              acc_d   = '0;
              low_d   = mag_b;
              opnd_d  = mag_a;
              neg_d   = sa ^ sb;
              negr_d  = 1'b0;
              isdiv_d = 1'b0;
              dz_d    = 1'b0;
              count_d = CW'(N);
              state_d = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              acc_d   = '0;
              low_d   = mag_a;
              opnd_d  = mag_b;
              orig_d  = srca;
              neg_d   = sa ^ sb;
              negr_d  = sa;
              isdiv_d = 1'b1;
              count_d = CW'(N);
              dz_d    = (srcb == '0);
              state_d = (srcb == '0) ? ST_FIX : ST_DIV;
            end
            OP_MTHI: hi_d = srca;
            OP_MTLO: lo_d = srca;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d   = step_acc;
          low_d   = step_low;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        // Architectural state only changes on an unflushed commit.
        if (!flush) begin
          done_d    = 1'b1;
          divzero_d = dz_q;
          if (!isdiv_q) begin
            hi_d = prod_s[2*N-1:N];
            lo_d = prod_s[N-1:0];
          end else if (dz_q) begin
            hi_d = orig_q;
            lo_d = '1;
          end else begin
            hi_d = rem_s;
            lo_d = quo_s;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      opnd_q    <= '0;
      orig_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      negr_q    <= 1'b0;
      isdiv_q   <= 1'b0;
      dz_q      <= 1'b0;
      divzero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      low_q     <= low_d;
      opnd_q    <= opnd_d;
      orig_q    <= orig_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      negr_q    <= negr_d;
      isdiv_q   <= isdiv_d;
      dz_q      <= dz_d;
      divzero_q <= divzero_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign stall   = busy & (start | rdhilo);
  assign done    = done_q;
  assign divzero = divzero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
`default_nettype wire
